par_ser_conv_32: RTL and testbench



---
 rtl/par_ser_pkg.sv | 14 +
 rtl/par_ser_datapath.sv | 79 +++++++
 rtl/par_ser_conv_32.sv | 138 +++++++++++++
 tb/tb_par_ser_conv_32.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/par_ser_pkg.sv
// par_ser_pkg: shared constants for the par_ser_conv_32 slice.
// Holds the FSM state encoding and the default word and counter widths.
package par_ser_pkg;

  // Control FSM encoding. S_PARITY is only reachable when PAR_SER_PARITY_EN is defined.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;

  // Default geometry: 32-bit words and a 5-bit bit counter.
  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_CNTR_WIDTH = 5;

endpackage

// File: rtl/par_ser_datapath.sv
// par_ser_datapath: shift register, bit counter and (optional) parity accumulator
// for the parallel-to-serial converter.
// Optional feature macro: PAR_SER_PARITY_EN (adds the even-parity accumulator).
// Strobe priority is clear > load > shift. The counter saturates at word_width-1,
// so the extra shift used to fold the final data bit into the parity never wraps it.
module par_ser_datapath
  import par_ser_pkg::*;
#(
  parameter int word_width = DEF_WORD_WIDTH,
  parameter int cntr_width = DEF_CNTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  clear,
  input  logic [word_width-1:0] data_in,
  output logic                  bit_out,
`ifdef PAR_SER_PARITY_EN
  output logic                  parity,
`endif
  output logic                  cntr_limit
);

  localparam logic [cntr_width-1:0] CNTR_LAST = cntr_width'(word_width - 1);

  logic [word_width-1:0] shreg_reg;
  logic [word_width-1:0] shreg_shifted;
  logic [cntr_width-1:0] cntr_reg;

  // Right shift by one with zero fill into the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < word_width - 1; gi++) begin : g_shift
      assign shreg_shifted[gi] = shreg_reg[gi + 1];
    end
  endgenerate
  assign shreg_shifted[word_width-1] = 1'b0;

  assign bit_out    = shreg_reg[0];
  assign cntr_limit = (cntr_reg == CNTR_LAST);

  // Shift register and bit counter: load a fresh word or advance one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_reg <= '0;
      cntr_reg  <= '0;
    end else if (clear) begin
      shreg_reg <= '0;
      cntr_reg  <= '0;
    end else if (load) begin
      shreg_reg <= data_in;
      cntr_reg  <= '0;
    end else if (shift) begin
      shreg_reg <= shreg_shifted;
      if (!cntr_limit) begin
        cntr_reg <= cntr_reg + cntr_width'(1);
      end
    end
  end

`ifdef PAR_SER_PARITY_EN
  logic parity_reg;

  assign parity = parity_reg;

  // Even-parity accumulator: XOR in each bit as it leaves the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_reg <= 1'b0;
    end else if (clear || load) begin
      parity_reg <= 1'b0;
    end else if (shift) begin
      parity_reg <= parity_reg ^ shreg_reg[0];
    end
  end
`endif

endmodule

// File: rtl/par_ser_conv_32.sv
// par_ser_conv_32: pops words from a first-word-fall-through FIFO and streams them
// LSB first, one bit per cycle in which the sink asserts En.
// Optional feature macro: PAR_SER_PARITY_EN (appends one even-parity bit per frame).
// read is Mealy so the next word is popped in the last-bit cycle, giving
// back-to-back frames with no idle bubble.
module par_ser_conv_32
  import par_ser_pkg::*;
#(
  parameter int word_width = DEF_WORD_WIDTH,
  parameter int cntr_width = DEF_CNTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [word_width-1:0] Data_in,
  input  logic                  empty,
  input  logic                  En,
  output logic                  read,
  output logic                  Data_out,
  output logic                  valid,
  output logic                  last,
  output logic                  ready
);

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       load;
  logic       shift;
  logic       clear;
  logic       bit_out;
  logic       cntr_limit;
`ifdef PAR_SER_PARITY_EN
  logic       parity;
`endif

  par_ser_datapath #(
    .word_width (word_width),
    .cntr_width (cntr_width)
  ) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .shift      (shift),
    .clear      (clear),
    .data_in    (Data_in),
    .bit_out    (bit_out),
`ifdef PAR_SER_PARITY_EN
    .parity     (parity),
`endif
    .cntr_limit (cntr_limit)
  );

  // Next-state and strobe decode; a pop is only ever issued together with a load.
  always_comb begin
    state_next = state_reg;
    read       = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    clear      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (En && !empty) begin
          read       = 1'b1;
          load       = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (En) begin
          if (!cntr_limit) begin
            shift = 1'b1;
          end else begin
`ifdef PAR_SER_PARITY_EN
            // Final data bit: shift once more so it is folded into the parity.
            shift      = 1'b1;
            state_next = S_PARITY;
`else
            if (!empty) begin
              read = 1'b1;
              load = 1'b1;
            end else begin
              clear      = 1'b1;
              state_next = S_IDLE;
            end
`endif
          end
        end
      end
`ifdef PAR_SER_PARITY_EN
      S_PARITY: begin
        if (En) begin
          if (!empty) begin
            read       = 1'b1;
            load       = 1'b1;
            state_next = S_SHIFT;
          end else begin
            clear      = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
`endif
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Serial outputs decoded from the current state; Data_out is forced low when idle.
  always_comb begin
    ready    = (state_reg == S_IDLE);
    valid    = (state_reg == S_SHIFT);
    Data_out = 1'b0;
    last     = 1'b0;
    if (state_reg == S_SHIFT) begin
      Data_out = bit_out;
`ifndef PAR_SER_PARITY_EN
      last     = cntr_limit;
`endif
    end
`ifdef PAR_SER_PARITY_EN
    if (state_reg == S_PARITY) begin
      valid    = 1'b1;
      Data_out = parity;
      last     = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_par_ser_conv_32.sv
// tb_par_ser_conv_32: directed self-checking bench for par_ser_conv_32.
// Honors PAR_SER_PARITY_EN (33-bit frames with a trailing even-parity bit).
module tb_par_ser_conv_32;

`ifdef PAR_SER_PARITY_EN
  localparam int FRAME_BITS = 33;
`else
  localparam int FRAME_BITS = 32;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] Data_in;
  logic        empty;
  logic        En;
  logic        read;
  logic        Data_out;
  logic        valid;
  logic        last;
  logic        ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] fifo[$];

  par_ser_conv_32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Data_in  (Data_in),
    .empty    (empty),
    .En       (En),
    .read     (read),
    .Data_out (Data_out),
    .valid    (valid),
    .last     (last),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [31:0] word;
    logic        en;
    logic        exp_read;
    logic        exp_valid;
    logic        exp_dout;
    logic        exp_last;
    logic        exp_ready;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  // Check all outputs against the expected set (reset is not advanced here).
  task automatic chk_all(input string nm, input logic e_read, input logic e_valid,
                         input logic e_dout, input logic e_last, input logic e_ready);
    chk({nm, ".read"},  read,     e_read);
    chk({nm, ".valid"}, valid,    e_valid);
    chk({nm, ".dout"},  Data_out, e_dout);
    chk({nm, ".last"},  last,     e_last);
    chk({nm, ".ready"}, ready,    e_ready);
  endtask

  // One clock cycle: present FIFO head and En, check outputs, then clock and pop.
  task automatic cyc(input logic en_v, input logic e_read, input logic e_valid,
                     input logic e_dout, input logic e_last, input logic e_ready,
                     input string nm);
    logic rd;
    En      = en_v;
    empty   = (fifo.size() == 0);
    Data_in = empty ? 32'hDEAD_BEEF : fifo[0];
    #1;
    chk_all(nm, e_read, e_valid, e_dout, e_last, e_ready);
    rd = read;
    @(posedge clk);
    if (rd && fifo.size() > 0) void'(fifo.pop_front());
    #1;
  endtask

  // Accepted frame bits from..to of word w with En held high.
  task automatic bits(input logic [31:0] w, input int from, input int to,
                      input logic next_avail, input string nm);
    logic b;
    logic lb;
    for (int i = from; i <= to; i++) begin
      b  = (i < 32) ? w[i] : ^w;
      lb = (i == FRAME_BITS - 1);
      cyc(1'b1, lb && next_avail, 1'b1, b, lb, 1'b0, $sformatf("%s.b%0d", nm, i));
    end
    if (to == FRAME_BITS - 1) $display("frame %s word=%08h complete", nm, w);
  endtask

  // Idle cycle that pops and loads the FIFO head.
  task automatic load_cyc(input string nm);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, {nm, ".load"});
  endtask

  initial begin
    // Table: idle behaviour, load of 0x0000_0003, first bits with a one-cycle stall.
    tbl[0] = '{1'b0, 32'h0,          1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 32'h0000_0003,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 32'h0,          1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 32'h0,          1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset values while rst_n is held low.
    rst_n   = 1'b0;
    En      = 1'b0;
    empty   = 1'b1;
    Data_in = 32'h0;
    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle with empty FIFO and En high: nothing happens.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("idle%0d", i));

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].push) fifo.push_back(tbl[i].word);
      cyc(tbl[i].en, tbl[i].exp_read, tbl[i].exp_valid, tbl[i].exp_dout,
          tbl[i].exp_last, tbl[i].exp_ready, $sformatf("tbl%0d", i));
    end
    bits(32'h0000_0003, 3, FRAME_BITS - 1, 1'b0, "w3");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "w3.idle");

    // Single word, En held high.
    fifo.push_back(32'hA5A5_0F01);
    load_cyc("a5");
    bits(32'hA5A5_0F01, 0, FRAME_BITS - 1, 1'b0, "a5");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "a5.idle");

    // Two queued words stream back to back.
    fifo.push_back(32'hFFFF_FFFF);
    fifo.push_back(32'h0000_0001);
    load_cyc("b2b");
    bits(32'hFFFF_FFFF, 0, FRAME_BITS - 1, 1'b1, "b2b_w0");
    bits(32'h0000_0001, 0, FRAME_BITS - 1, 1'b0, "b2b_w1");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "b2b.idle");

    // En low for three cycles at bit 7 of 0x0000_0080.
    fifo.push_back(32'h0000_0080);
    load_cyc("stall");
    bits(32'h0000_0080, 0, 6, 1'b0, "stall");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, $sformatf("stall.hold%0d", i));
    bits(32'h0000_0080, 7, FRAME_BITS - 1, 1'b0, "stall");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "stall.idle");

    // FIFO becomes non-empty mid-frame: no pop until the last-bit cycle.
    fifo.push_back(32'h1234_5678);
    load_cyc("tog");
    bits(32'h1234_5678, 0, 9, 1'b0, "tog_w0");
    fifo.push_back(32'hCAFE_F00D);
    bits(32'h1234_5678, 10, FRAME_BITS - 1, 1'b1, "tog_w0");
    bits(32'hCAFE_F00D, 0, FRAME_BITS - 1, 1'b0, "tog_w1");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "tog.idle");

    // Reset pulsed at bit 12: popped word discarded, next word loads cleanly.
    fifo.push_back(32'h0000_1000);
    fifo.push_back(32'h0000_0005);
    load_cyc("rst");
    bits(32'h0000_1000, 0, 11, 1'b0, "rst_w0");
    En      = 1'b1;
    empty   = 1'b0;
    Data_in = fifo[0];
    #1;
    chk("rst.b12.dout", Data_out, 1'b1);
    chk("rst.b12.valid", valid, 1'b1);
    En    = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all("rst.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_all("rst.held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst.post0");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst.post1");
    load_cyc("rst_w1");
    bits(32'h0000_0005, 0, FRAME_BITS - 1, 1'b0, "rst_w1");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst.idle");

`ifdef PAR_SER_PARITY_EN
    // Parity frame: 0x0000_0007 has odd weight, so the appended bit is 1.
    fifo.push_back(32'h0000_0007);
    load_cyc("par7");
    bits(32'h0000_0007, 0, 31, 1'b0, "par7");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "par7.parity");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "par7.idle");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
